onehot_pulse_decoder: RTL and testbench

Sequenced binary-to-one-hot decoder: accepts 2-bit codes over a valid/ready handshake, buffers them in a small FIFO, and drives each as a one-hot 4-bit strobe held for a fixed number of cycles, separated by an all-zero gap. It is the decode-side counterpart of the one-hot-to-binary encoder and sits between a code-producing controller and the one-hot select lines it steers.

---
 rtl/onehot_pkg.sv | 18 +
 rtl/onehot_pulse_decoder_fifo.sv | 56 +++++
 rtl/onehot_pulse_decoder.sv | 124 ++++++++++++
 tb/tb_onehot_pulse_decoder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/onehot_pkg.sv
// Shared types and helpers for the one-hot decode/encode pair.
package onehot_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int unsigned ONEHOT_MAX_W = 32;
  localparam int unsigned CODE_MAX_W   = 5;

  // Codes wider than CODE_MAX_W bits are not supported by this helper.
  function automatic logic [ONEHOT_MAX_W-1:0] onehot_of(input logic [CODE_MAX_W-1:0] code);
    return ONEHOT_MAX_W'(1) << code;
  endfunction

endpackage

// File: rtl/onehot_pulse_decoder_fifo.sv
// Small synchronous FIFO with occupancy count; read data is the current head.
module sync_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_wr;
  logic             do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule

// File: rtl/onehot_pulse_decoder.sv
// Buffers binary codes and replays each as a timed one-hot strobe followed by an idle gap.
module onehot_pulse_decoder
  import onehot_pkg::*;
#(
  parameter  int unsigned IN_W      = 2,
  parameter  int unsigned PULSE_LEN = 4,
  parameter  int unsigned GAP_LEN   = 1,
  parameter  int unsigned DEPTH     = 4,
  localparam int unsigned OUT_W     = 1 << IN_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [IN_W-1:0]         in_code,
  output logic                    in_ready,
  output logic [OUT_W-1:0]        out,
  output logic                    out_valid,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              pop;
  logic              full;
  logic              empty;
  logic [IN_W-1:0]   head;
  logic [OUT_W-1:0]  strobe;

  sync_fifo #(
    .WIDTH (IN_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (in_valid),
    .wr_data (in_code),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign strobe = OUT_W'(onehot_of(CODE_MAX_W'(head)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state: load a strobe from the FIFO head, hold it, then idle for the gap.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        out_d       = '0;
        out_valid_d = 1'b0;
        if (!empty) begin
          pop         = 1'b1;
          out_d       = strobe;
          out_valid_d = 1'b1;
          cnt_d       = CNT_W'(PULSE_LEN - 1);
          state_d     = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          out_d       = '0;
          out_valid_d = 1'b0;
          if (GAP_LEN != 0) begin
            cnt_d   = CNT_W'(GAP_LEN - 1);
            state_d = GAP;
          end else if (!empty) begin
            // Zero-gap mode chains the next strobe with no dead cycle.
            pop         = 1'b1;
            out_d       = strobe;
            out_valid_d = 1'b1;
            cnt_d       = CNT_W'(PULSE_LEN - 1);
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        out_d       = '0;
        out_valid_d = 1'b0;
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: begin
        state_d     = IDLE;
        out_d       = '0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign in_ready  = !full;
  assign busy      = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Bench for onehot_pulse_decoder: lane 0 runs GAP_LEN=1, lane 1 runs GAP_LEN=0.
module tb_onehot_pulse_decoder;

  localparam int PULSE = 4;

  typedef struct {
    logic [1:0] code;
    logic [3:0] exp_out;
  } vec_t;

  logic            clk = 1'b0;
  logic [1:0]      rst_n;
  logic [1:0]      in_valid;
  logic [1:0][1:0] in_code;
  logic [1:0]      in_ready;
  logic [1:0][3:0] out_s;
  logic [1:0]      out_valid;
  logic [1:0]      busy;
  logic [1:0][2:0] count;

  int checks = 0;
  int errors = 0;
  vec_t vecs [4];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_lane
    logic [1:0] q [$];
    logic [3:0] prev = '0;
    int         run = 0;
    int         max_cnt = 0;

    onehot_pulse_decoder #(
      .IN_W      (2),
      .PULSE_LEN (PULSE),
      .GAP_LEN   ((g == 0) ? 1 : 0),
      .DEPTH     (4)
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .in_valid  (in_valid[g]),
      .in_code   (in_code[g]),
      .in_ready  (in_ready[g]),
      .out       (out_s[g]),
      .out_valid (out_valid[g]),
      .busy      (busy[g]),
      .count     (count[g])
    );

    // Expected strobe order is captured at the accepting edge.
    always @(posedge clk) begin
      if (rst_n[g] && in_valid[g] && in_ready[g]) q.push_back(in_code[g]);
    end

    always @(negedge clk) begin : mon
      logic [3:0] cur;
      logic       fresh;
      logic [1:0] exp_code;
      if (!rst_n[g]) begin
        q.delete();
        prev = '0;
        run  = 0;
      end else begin
        cur = out_s[g];
        if (int'(count[g]) > max_cnt) max_cnt = int'(count[g]);
        fresh = (cur != 0) && ((prev == 0) || (cur != prev) || (run == PULSE));
        if ((prev != 0) && ((cur == 0) || fresh)) check("pulse_len", 32'(run), 32'(PULSE));
        check("valid_tracks_out", 32'(out_valid[g]), 32'(cur != 0));
        if (fresh) begin
          if (q.size() == 0) begin
            check("unexpected_strobe", 32'(cur), 32'(0));
          end else begin
            exp_code = q.pop_front();
            check("strobe_code", 32'(cur), 32'(1) << exp_code);
          end
          run = 1;
        end else if (cur != 0) begin
          run++;
        end
        prev = cur;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge, in_valid still high.
  task automatic push(input int d, input logic [1:0] c);
    int n;
    n = 0;
    in_valid[d] = 1'b1;
    in_code[d]  = c;
    while (!in_ready[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("push_timeout", 32'(n), 32'(0));
    @(negedge clk);
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while ((busy[d] || out_valid[d]) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("drain_timeout", 32'(n), 32'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int nz;
    int run_len;
    logic [1:0] c;

    vecs[0] = '{code: 2'b10, exp_out: 4'b0100};
    vecs[1] = '{code: 2'b00, exp_out: 4'b0001};
    vecs[2] = '{code: 2'b11, exp_out: 4'b1000};
    vecs[3] = '{code: 2'b01, exp_out: 4'b0010};

    rst_n    = '0;
    in_valid = '0;
    in_code  = '0;

    // Defaults are visible while reset is still asserted.
    #12;
    check("rst_in_ready0", 32'(in_ready[0]), 32'(1));
    check("rst_in_ready1", 32'(in_ready[1]), 32'(1));
    check("rst_out", 32'(out_s[0]), 32'(0));
    check("rst_out_valid", 32'(out_valid[0]), 32'(0));
    check("rst_count", 32'(count[0]), 32'(0));
    @(negedge clk);
    rst_n = '1;
    @(negedge clk);
    check("post_rst_out", 32'(out_s[0]), 32'(0));
    check("post_rst_in_ready", 32'(in_ready[0]), 32'(1));
    check("post_rst_busy", 32'(busy[0]), 32'(0));

    // Single codes: strobe on edges N+1..N+4, zero at N+5, idle by N+6.
    for (int i = 0; i < 4; i++) begin
      check("idle_before", 32'(busy[0]), 32'(0));
      push(0, vecs[i].code);
      in_valid[0] = 1'b0;
      check("count_after_push", 32'(count[0]), 32'(1));
      for (int k = 1; k <= PULSE; k++) begin
        @(negedge clk);
        check("strobe_hold", 32'(out_s[0]), 32'(vecs[i].exp_out));
      end
      @(negedge clk);
      check("strobe_end", 32'(out_s[0]), 32'(0));
      @(negedge clk);
      check("busy_clear", 32'(busy[0]), 32'(0));
    end

    // Full FIFO: first code is popped at once, next four fill it, sixth waits for a pop.
    for (int i = 0; i < 6; i++) begin
      c = 2'(i);
      push(0, c);
      if (i == 4) begin
        check("full_count", 32'(count[0]), 32'(4));
        check("full_not_ready", 32'(in_ready[0]), 32'(0));
      end
    end
    in_valid[0] = 1'b0;
    wait_idle(0);
    check("full_drained", 32'(g_lane[0].q.size()), 32'(0));

    // Zero gap: four codes play as one unbroken 16-cycle run; 3 cycles already elapsed here.
    push(1, 2'b00);
    push(1, 2'b01);
    push(1, 2'b10);
    push(1, 2'b11);
    in_valid[1] = 1'b0;
    run_len = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_s[1] == 0) break;
      run_len++;
    end
    check("b2b_remaining_run", 32'(run_len), 32'(13));
    wait_idle(1);
    check("b2b_drained", 32'(g_lane[1].q.size()), 32'(0));

    // Async reset in the middle of the second cycle of 4'b1000.
    push(1, 2'b11);
    push(1, 2'b00);
    push(1, 2'b01);
    in_valid[1] = 1'b0;
    check("pre_reset_out", 32'(out_s[1]), 32'(4'b1000));
    rst_n[1] = 1'b0;
    #1;
    check("abort_out", 32'(out_s[1]), 32'(0));
    check("abort_out_valid", 32'(out_valid[1]), 32'(0));
    check("abort_count", 32'(count[1]), 32'(0));
    check("abort_in_ready", 32'(in_ready[1]), 32'(1));
    @(negedge clk);
    rst_n[1] = 1'b1;
    nz = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_s[1] != 0) nz++;
    end
    check("no_residue", 32'(nz), 32'(0));

    // Wrap-around: ten random codes through the 4-deep FIFO.
    for (int i = 0; i < 10; i++) begin
      c = 2'($urandom_range(3));
      push(0, c);
    end
    in_valid[0] = 1'b0;
    wait_idle(0);
    check("wrap_drained", 32'(g_lane[0].q.size()), 32'(0));
    check("max_count", 32'(g_lane[0].max_cnt), 32'(4));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
